// File: rtl/mul_pkg.sv
// Shared types and constants for the multiply operand-conditioning stage
// and the downstream multiply finish stage.
// Optional build macro: MUL_PREP_RANGE_CHK_EN adds a per-entry range_err flag.
package mul_pkg;

    localparam int XLEN  = 32;
    localparam int MAG_W = 10;
    localparam int RD_W  = 5;

    // M-extension multiply flavours, encoded as funct3[1:0]
    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    // Skid-buffer occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } occ_e;

    // One conditioned request as seen by the finish stage
    typedef struct packed {
        logic             sign;
        logic             upper;
        logic [MAG_W-1:0] rs1_u;
        logic [MAG_W-1:0] rs2_u;
        logic [RD_W-1:0]  rd;
`ifdef MUL_PREP_RANGE_CHK_EN
        logic             range_err;
`endif
    } mul_ent_t;

    // Unsigned magnitude of an operand; two's-complement negation when the
    // operand is treated as signed and negative (0x80000000 maps to itself).
    function automatic logic [XLEN-1:0] cond_mag(input logic [XLEN-1:0] x,
                                                 input logic            is_signed);
        logic [XLEN-1:0] r;
        if (is_signed && x[XLEN-1]) begin
            r = ~x + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_prep_cond.sv
// Purely combinational operand conditioning: funct3/rs1/rs2/rd -> mul_ent_t.
// Optional build macro: MUL_PREP_RANGE_CHK_EN fills the range_err field.
module mul_prep_cond
    import mul_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [RD_W-1:0] rd_i,
    output logic            op_valid_o,
    output mul_ent_t        ent_o
);

    logic            rs1_signed_s;
    logic            rs2_signed_s;
    logic            neg1_s;
    logic            neg2_s;
    logic [XLEN-1:0] mag1_s;
    logic [XLEN-1:0] mag2_s;

    // Decode which operands are interpreted as signed for this flavour
    always_comb begin
        rs1_signed_s = 1'b0;
        rs2_signed_s = 1'b0;
        case (funct3_i)
            {1'b0, MUL},
            {1'b0, MULH}: begin
                rs1_signed_s = 1'b1;
                rs2_signed_s = 1'b1;
            end
            {1'b0, MULHSU}: begin
                rs1_signed_s = 1'b1;
                rs2_signed_s = 1'b0;
            end
            default: begin
                rs1_signed_s = 1'b0;
                rs2_signed_s = 1'b0;
            end
        endcase
    end

    assign neg1_s = rs1_signed_s & rs1_i[XLEN-1];
    assign neg2_s = rs2_signed_s & rs2_i[XLEN-1];
    assign mag1_s = cond_mag(rs1_i, rs1_signed_s);
    assign mag2_s = cond_mag(rs2_i, rs2_signed_s);

    // Non-multiply encodings (funct3[2]=1) are handshaken but never stored
    assign op_valid_o = ~funct3_i[2];

    // Assemble the entry; magnitude bits at or above MAG_W are dropped
    always_comb begin
        ent_o       = '0;
        ent_o.sign  = neg1_s ^ neg2_s;
        ent_o.upper = (funct3_i != 3'b000);
        ent_o.rs1_u = mag1_s[MAG_W-1:0];
        ent_o.rs2_u = mag2_s[MAG_W-1:0];
        ent_o.rd    = rd_i;
`ifdef MUL_PREP_RANGE_CHK_EN
        ent_o.range_err = (|mag1_s[XLEN-1:MAG_W]) | (|mag2_s[XLEN-1:MAG_W]);
`endif
    end

`ifndef MUL_PREP_RANGE_CHK_EN
    // High magnitude bits are intentionally discarded in this build
    logic unused_mag_hi_s;
    assign unused_mag_hi_s = ^{mag1_s[XLEN-1:MAG_W], mag2_s[XLEN-1:MAG_W]};
`endif

endmodule

// File: rtl/mul_prep.sv
// Multiply operand-conditioning stage with a 2-entry skid buffer in front of
// the multiply finish stage. IN_READY is a pure register output.
// Optional build macro: MUL_PREP_RANGE_CHK_EN adds the RANGE_ERR output.
// XLEN/MAG_W/RD_W must match the mul_pkg constants (the entry type is shared).
module mul_prep #(
    parameter int XLEN  = mul_pkg::XLEN,
    parameter int MAG_W = mul_pkg::MAG_W,
    parameter int RD_W  = mul_pkg::RD_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       IN_FUNCT3,
    input  logic [XLEN-1:0]  IN_RS1,
    input  logic [XLEN-1:0]  IN_RS2,
    input  logic [RD_W-1:0]  IN_RD,
    input  logic             OUT_READY,
    output logic             OUT_VALID,
    output logic             EN,
    output logic             SIGN,
    output logic             UPPER,
    output logic [MAG_W-1:0] RS1_U_END,
    output logic [MAG_W-1:0] RS2_U_END,
    output logic [RD_W-1:0]  OUT_RD
`ifdef MUL_PREP_RANGE_CHK_EN
    ,
    output logic             RANGE_ERR
`endif
);

    import mul_pkg::*;

    occ_e     state_q, state_d;
    mul_ent_t head_q,  head_d;
    mul_ent_t skid_q,  skid_d;
    logic     in_ready_q, in_ready_d;

    logic     op_valid_s;
    mul_ent_t cond_ent_s;
    logic     accept_s;
    logic     wr_s;
    logic     pop_s;
    logic     out_valid_s;

    mul_prep_cond u_cond (
        .funct3_i   (IN_FUNCT3),
        .rs1_i      (IN_RS1),
        .rs2_i      (IN_RS2),
        .rd_i       (IN_RD),
        .op_valid_o (op_valid_s),
        .ent_o      (cond_ent_s)
    );

    assign out_valid_s = (state_q != ST_EMPTY);
    assign accept_s    = IN_VALID & in_ready_q;
    assign wr_s        = accept_s & op_valid_s;
    assign pop_s       = out_valid_s & OUT_READY;

    // Occupancy next-state and entry movement; FLUSH overrides everything
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (FLUSH) begin
            state_d = ST_EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (wr_s) begin
                        head_d  = cond_ent_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (wr_s && !pop_s) begin
                        skid_d  = cond_ent_s;
                        state_d = ST_TWO;
                    end else if (wr_s && pop_s) begin
                        head_d  = cond_ent_s;
                        state_d = ST_ONE;
                    end else if (pop_s) begin
                        head_d  = '0;
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // IN_READY is low here, so only a pop can happen
                    if (pop_s) begin
                        head_d  = skid_q;
                        skid_d  = '0;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    head_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
        in_ready_d = (state_d != ST_TWO);
    end

    // State, entry storage and registered ready; async clear on RST
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_s;
    assign EN        = out_valid_s;
    assign SIGN      = head_q.sign;
    assign UPPER     = head_q.upper;
    assign RS1_U_END = head_q.rs1_u;
    assign RS2_U_END = head_q.rs2_u;
    assign OUT_RD    = head_q.rd;
`ifdef MUL_PREP_RANGE_CHK_EN
    assign RANGE_ERR = head_q.range_err;
`endif

endmodule

// File: tb/tb_mul_prep.sv
// Self-checking bench for mul_prep: directed conditioning vectors, backpressure,
// flush, reset and a randomized stream against a queue-based reference model.
// Honours MUL_PREP_RANGE_CHK_EN when defined.
module tb_mul_prep;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic        out_ready;
    logic        out_valid;
    logic        en;
    logic        sign;
    logic        upper;
    logic [9:0]  rs1_u;
    logic [9:0]  rs2_u;
    logic [4:0]  out_rd;
`ifdef MUL_PREP_RANGE_CHK_EN
    logic        range_err;
`endif

    int passed = 0;
    int total  = 0;

    typedef struct {
        bit       sign;
        bit       upper;
        bit [9:0] m1;
        bit [9:0] m2;
        bit [4:0] rd;
        bit       rerr;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    mul_prep dut (
        .CLK       (clk),
        .RST       (rst),
        .FLUSH     (flush),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN_FUNCT3 (in_funct3),
        .IN_RS1    (in_rs1),
        .IN_RS2    (in_rs2),
        .IN_RD     (in_rd),
        .OUT_READY (out_ready),
        .OUT_VALID (out_valid),
        .EN        (en),
        .SIGN      (sign),
        .UPPER     (upper),
        .RS1_U_END (rs1_u),
        .RS2_U_END (rs2_u),
        .OUT_RD    (out_rd)
`ifdef MUL_PREP_RANGE_CHK_EN
        ,
        .RANGE_ERR (range_err)
`endif
    );

    // Reference: true mathematical value of each operand, then |v| and its sign
    function automatic exp_t ref_model(bit [2:0] f3, bit [31:0] a, bit [31:0] b, bit [4:0] rd);
        exp_t   r;
        longint va;
        longint vb;
        bit     s1 = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        bit     s2 = (f3 == 3'd0) || (f3 == 3'd1);
        va = s1 ? longint'($signed(a)) : longint'(a);
        vb = s2 ? longint'($signed(b)) : longint'(b);
        r.sign  = (va < 0) ^ (vb < 0);
        r.upper = (f3 != 3'd0);
        if (va < 0) va = -va;
        if (vb < 0) vb = -vb;
        r.m1   = va[9:0];
        r.m2   = vb[9:0];
        r.rd   = rd;
        r.rerr = (va >= 64'sd1024) || (vb >= 64'sd1024);
        return r;
    endfunction

    function automatic logic [26:0] dut_head();
        return {sign, upper, rs1_u, rs2_u, out_rd};
    endfunction

    function automatic logic [26:0] pack_exp(exp_t e);
        return {e.sign, e.upper, e.m1, e.m2, e.rd};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0:       v = 32'($urandom_range(0, 1023));
            1:       v = 32'd0 - 32'($urandom_range(1, 1024));
            2:       v = 32'h8000_0000;
            3:       v = $urandom;
            default: v = ($urandom_range(0, 1) == 0) ? 32'h0000_0000 : 32'hFFFF_FFFF;
        endcase
        return v;
    endfunction

    task automatic drive_idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        in_funct3 = 3'd0;
        in_rs1    = 32'd0;
        in_rs2    = 32'd0;
        in_rd     = 5'd0;
    endtask

    // Empty the buffer with a one-cycle flush
    task automatic clear_buffer();
        @(negedge clk);
        drive_idle();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        drive_idle();
        #2;
        total++;
        if ({in_ready, out_valid, en, dut_head()} !== 30'd0) begin
            $display("FAIL reset_outputs: got %h expected 0", {in_ready, out_valid, en, dut_head()});
        end else passed++;
`ifdef MUL_PREP_RANGE_CHK_EN
        total++;
        if (range_err !== 1'b0) $display("FAIL reset_range_err: got %b expected 0", range_err);
        else passed++;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end else passed++;
    endtask

    task automatic test_conditioning();
        logic [2:0]  f3_t  [7] = '{3'd1, 3'd3, 3'd2, 3'd0, 3'd0, 3'd1, 3'd2};
        logic [31:0] a_t   [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0,
                                   32'h400, 32'h8000_0000, 32'd5};
        logic [31:0] b_t   [7] = '{32'd5, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'd1, 32'd1, 32'h8000_0000};
        logic [4:0]  rd_t  [7] = '{5'd7, 5'd1, 5'd2, 5'd3, 5'd4, 5'd31, 5'd9};
        logic [26:0] exp_t_[7] = '{{1'b1, 1'b1, 10'd3,     10'd5,     5'd7},
                                   {1'b0, 1'b1, 10'h3FD,   10'd2,     5'd1},
                                   {1'b1, 1'b1, 10'd2,     10'h3FF,   5'd2},
                                   {1'b1, 1'b0, 10'd0,     10'd1,     5'd3},
                                   {1'b0, 1'b0, 10'd0,     10'd1,     5'd4},
                                   {1'b1, 1'b1, 10'd0,     10'd1,     5'd31},
                                   {1'b0, 1'b1, 10'd5,     10'd0,     5'd9}};
        logic        rerr_t[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        clear_buffer();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_funct3 = f3_t[i];
            in_rs1    = a_t[i];
            in_rs2    = b_t[i];
            in_rd     = rd_t[i];
            @(negedge clk);
            in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b1 || en !== 1'b1 || dut_head() !== exp_t_[i]) begin
                $display("FAIL cond_vec%0d: valid=%b en=%b head=%h expected valid=1 head=%h",
                         i, out_valid, en, dut_head(), exp_t_[i]);
            end else passed++;
`ifdef MUL_PREP_RANGE_CHK_EN
            total++;
            if (range_err !== rerr_t[i]) begin
                $display("FAIL cond_range%0d: got %b expected %b", i, range_err, rerr_t[i]);
            end else passed++;
`else
            if (rerr_t[i] === 1'bx) $display("unexpected table value");
`endif
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) $display("FAIL cond_drain: out_valid=%b expected 0", out_valid);
        else passed++;
    endtask

    task automatic test_discard();
        clear_buffer();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b1;
        in_funct3 = 3'b101;
        in_rs1    = 32'd7;
        in_rs2    = 32'd9;
        in_rd     = 5'd12;
        total++;
        if (in_ready !== 1'b1) $display("FAIL discard_ready: got %b expected 1", in_ready);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL discard_nowrite: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end else passed++;
    endtask

    task automatic test_backpressure();
        logic [26:0] exp_a = {1'b1, 1'b0, 10'd7, 10'd3, 5'd10};
        logic [26:0] exp_b = {1'b0, 1'b1, 10'd100, 10'd200, 5'd11};
        clear_buffer();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_funct3 = 3'd0; in_rs1 = 32'hFFFF_FFF9; in_rs2 = 32'd3; in_rd = 5'd10;
        @(negedge clk);
        in_funct3 = 3'd3; in_rs1 = 32'd100; in_rs2 = 32'd200; in_rd = 5'd11;
        total++;
        if (in_ready !== 1'b1 || dut_head() !== exp_a) begin
            $display("FAIL bp_one: in_ready=%b head=%h expected 1 / %h", in_ready, dut_head(), exp_a);
        end else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || dut_head() !== exp_a) begin
            $display("FAIL bp_full: in_ready=%b valid=%b head=%h expected 0/1/%h",
                     in_ready, out_valid, dut_head(), exp_a);
        end else passed++;
        @(negedge clk);
        total++;
        if (dut_head() !== exp_a || in_ready !== 1'b0) begin
            $display("FAIL bp_stable: head=%h in_ready=%b expected %h/0", dut_head(), in_ready, exp_a);
        end else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || dut_head() !== exp_b || in_ready !== 1'b1) begin
            $display("FAIL bp_second: valid=%b head=%h in_ready=%b expected 1/%h/1",
                     out_valid, dut_head(), in_ready, exp_b);
        end else passed++;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL bp_drain: valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end else passed++;
    endtask

    task automatic test_flush();
        for (int fill = 2; fill >= 1; fill--) begin
            clear_buffer();
            out_ready = 1'b0;
            for (int k = 0; k < fill; k++) begin
                @(negedge clk);
                in_valid = 1'b1; in_funct3 = 3'd1; in_rs1 = 32'd5 + 32'(k); in_rs2 = 32'd6; in_rd = 5'(k + 1);
            end
            @(negedge clk);
            flush = 1'b1;
            in_valid = 1'b1; in_funct3 = 3'd0; in_rs1 = 32'd9; in_rs2 = 32'd9; in_rd = 5'd20;
            @(negedge clk);
            flush = 1'b0;
            in_valid = 1'b0;
            out_ready = 1'b1;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_head() !== 27'd0) begin
                $display("FAIL flush_fill%0d: valid=%b in_ready=%b head=%h expected 0/1/0",
                         fill, out_valid, in_ready, dut_head());
            end else passed++;
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) $display("FAIL flush_quiet%0d: valid=%b expected 0", fill, out_valid);
            else passed++;
        end
    endtask

    task automatic test_rst_mid();
        clear_buffer();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_funct3 = 3'd1; in_rs1 = 32'hFFFF_FFFF; in_rs2 = 32'd3; in_rd = 5'd17;
        @(negedge clk);
        in_valid = 1'b1; in_rd = 5'd18;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({in_ready, out_valid, en, dut_head()} !== 30'd0) begin
            $display("FAIL rst_mid: got %h expected 0", {in_ready, out_valid, en, dut_head()});
        end else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL rst_mid_release: in_ready=%b valid=%b expected 1/0", in_ready, out_valid);
        end else passed++;
    endtask

    task automatic test_random();
        exp_t e;
        bit   pop;
        bit   acc;
        clear_buffer();
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            total++;
            if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0) || en !== (q.size() > 0)) begin
                $display("FAIL rand_flags cyc%0d: in_ready=%b valid=%b en=%b expected %b/%b",
                         cyc, in_ready, out_valid, en, q.size() < 2, q.size() > 0);
            end else passed++;
            if (q.size() > 0) begin
                total++;
                if (dut_head() !== pack_exp(q[0])) begin
                    $display("FAIL rand_head cyc%0d: got %h expected %h", cyc, dut_head(), pack_exp(q[0]));
                end else passed++;
`ifdef MUL_PREP_RANGE_CHK_EN
                total++;
                if (range_err !== q[0].rerr) begin
                    $display("FAIL rand_range cyc%0d: got %b expected %b", cyc, range_err, q[0].rerr);
                end else passed++;
`endif
            end
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_funct3 = 3'($urandom_range(0, 7));
            in_rs1    = rand_op();
            in_rs2    = rand_op();
            in_rd     = 5'($urandom_range(0, 31));
            if (flush) begin
                q.delete();
            end else begin
                pop = (q.size() > 0) && out_ready;
                acc = in_valid && (q.size() < 2);
                if (pop) void'(q.pop_front());
                if (acc && !in_funct3[2]) begin
                    e = ref_model(in_funct3, in_rs1, in_rs2, in_rd);
                    q.push_back(e);
                end
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_conditioning();
        test_discard();
        test_backpressure();
        test_flush();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
